traffic_phase_sequencer: RTL

Two-approach intersection controller that sequences north-south (NS) and east-west (EW) signal heads through timed green/yellow/all-red phases. It adds a latched pedestrian walk phase and an emergency-vehicle preemption hold. It drives the per-approach 2-bit light codes consumed by the signal-head drivers and sits between the request sensors and those drivers.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/phase_timer.sv | 18 +
 rtl/traffic_phase_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, controller states and a parameter helper for traffic_phase_sequencer
package traffic_pkg;
  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b10;
  localparam logic [1:0] LIGHT_OFF = 2'b11;
  typedef enum logic [2:0] {
    RED_A    = 3'd0,
    NS_GRN   = 3'd1,
    NS_YEL   = 3'd2,
    RED_B    = 3'd3,
    EW_GRN   = 3'd4,
    EW_YEL   = 3'd5,
    PED_WALK = 3'd6,
    PREEMPT  = 3'd7
  } state_t;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down counter; ports clk, reset_n, load, load_value in, zero out (count == 0)
module phase_timer #(
  parameter int W = 4,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= RESET_VALUE;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: NS/EW signal sequencer with ped walk and emergency preemption; ports clk, reset_n, ped_req, emerg_req, emerg_dir in; ns_light, ew_light, walk, ped_ack, phase out
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);
  localparam int CW = $clog2(max4(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES)) + 1;
  state_t state, next;
  logic ped_pending, preempt_dir, expired, load, entering_walk, accept;
  logic [CW-1:0] load_value;
  always_comb begin
    next = state;
    case (state)
      RED_A:    if (expired) next = emerg_req ? PREEMPT : NS_GRN;
      NS_GRN:   next = (emerg_req && emerg_dir) ? NS_YEL : emerg_req ? PREEMPT : expired ? NS_YEL : NS_GRN;
      NS_YEL:   if (expired) next = RED_B;
      RED_B:    if (expired) next = emerg_req ? PREEMPT : EW_GRN;
      EW_GRN:   next = (emerg_req && !emerg_dir) ? EW_YEL : emerg_req ? PREEMPT : expired ? EW_YEL : EW_GRN;
      EW_YEL:   if (expired) next = ped_pending ? PED_WALK : RED_A;
      PED_WALK: if (expired) next = emerg_req ? PREEMPT : RED_A;
      default:  if (!(emerg_req && emerg_dir == preempt_dir)) next = preempt_dir ? EW_YEL : NS_YEL;
    endcase
  end
  // counter is reloaded on every state change, so it never needs to wrap
  assign load = next != state;
  assign load_value = (next == NS_GRN || next == EW_GRN) ? CW'(GREEN_CYCLES - 1) :
                      (next == NS_YEL || next == EW_YEL) ? CW'(YELLOW_CYCLES - 1) :
                      (next == RED_A || next == RED_B)   ? CW'(ALLRED_CYCLES - 1) :
                      (next == PED_WALK)                 ? CW'(WALK_CYCLES - 1) : '0;
  phase_timer #(.W(CW), .RESET_VALUE(CW'(ALLRED_CYCLES - 1))) u_timer (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value), .zero(expired)
  );
  // a request arriving on the walk-entry edge re-arms the latch for the next round
  assign entering_walk = next == PED_WALK && state != PED_WALK;
  assign accept = ped_req && (!ped_pending || entering_walk);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RED_A;
      ped_pending <= 1'b0;
      preempt_dir <= 1'b0;
      ped_ack <= 1'b0;
    end else begin
      state <= next;
      ped_pending <= accept ? 1'b1 : entering_walk ? 1'b0 : ped_pending;
      ped_ack <= accept;
      if (next == PREEMPT && state != PREEMPT) preempt_dir <= emerg_dir;
    end
  assign ns_light = (state == NS_GRN || (state == PREEMPT && !preempt_dir)) ? LIGHT_GRN :
                    state == NS_YEL ? LIGHT_YEL : LIGHT_RED;
  assign ew_light = (state == EW_GRN || (state == PREEMPT && preempt_dir)) ? LIGHT_GRN :
                    state == EW_YEL ? LIGHT_YEL : LIGHT_RED;
  assign walk = state == PED_WALK;
  assign phase = state;
endmodule
